lfsr_encoder: RTL and testbench
===============================

# lfsr_encoder

- **Role:** message-encryption stage that produces the ciphertext the downstream LFSR decoder consumes.
- **Start:** begins when `init` falls.
- **Inputs from data memory:** a 7-bit ASCII plaintext and three configuration bytes.
- **Output to data memory:** 64 encrypted bytes at addresses 64..127.
  - Space preamble first, then the message.
  - Each byte carries even parity in bit 7, then is XORed with an 8-bit Fibonacci LFSR.
- **Done:** `done` raises when the last byte is written.

## Interface

Parameters:
- `MSG_LEN`, default 64: ciphertext bytes produced.
- `PRE_MIN`, default 9: minimum preamble length. The decoder needs 9 spaces to identify the tap pattern.
- `PRE_MAX`, default 24: maximum preamble length.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `init` input 1: synchronous, active-high reset. While high, the block idles. The first edge that samples it low starts a run.
- `rd_addr` output 8: data-memory read address. Read is asynchronous (combinational).
- `rd_data` input 8: data-memory read data.
- `wr_en` output 1: data-memory write strobe. Write commits on the `clk` rising edge.
- `wr_addr` output 8: write address.
- `wr_data` output 8: write data.
- `done` output 1: run complete. Held high until `init` rises.

## Operation

Memory map:
- 0..63: plaintext characters.
- 61: preamble length P.
- 62: tap select; bits [2:0] are used.
- 63: seed.
- 64..127: ciphertext.
- The config bytes at 61..63 are read before any plaintext is read.

Configuration rules:
- P: clamp to [PRE_MIN, PRE_MAX]. Example: 3 becomes 9; 200 becomes 24.
- Taps: chosen by tap select from the table E1, D4, C6, B8, B4, B2, FA, F3 (indices 0..7).
- Seed: a seed of 00 is forced to 01 (avoids LFSR lockup).

LFSR:
- State s0 = seed.
- Next state = {s[6:0], ^(s & taps)}.
- Byte k is encrypted with state sk. The LFSR advances once per byte written.

Plaintext for byte k:
- If k < P: the character is 0x20.
- Otherwise: the character is the byte read from address k−P. Bit 7 of that byte is ignored.
- Final plaintext byte = {^c[6:0], c[6:0]}, where c is the character. Space therefore encodes as A0.

Output for byte k: `wr_addr` = 64+k; `wr_data` = plaintext byte XOR sk.

FSM states:
- IDLE: entered whenever `init` is high.
- RD_PRE: drive `rd_addr` = 61; capture and clamp P.
- RD_TAP: drive `rd_addr` = 62; capture taps.
- RD_SEED: drive `rd_addr` = 63; load the LFSR.
- RUN: k = 0..MSG_LEN−1, one write per cycle.
- DONE.

Rules in RUN:
- `rd_addr` = k−P when k ≥ P, else 0.
- `wr_en` is high only in RUN.
- Reads (0..63) and writes (64..127) never collide.
- DONE holds until `init` rises.

## Timing

Reset values (edge with `init` high):
- state IDLE, k = 0, `done` = 0, `wr_en` = 0, `rd_addr` = 0.
- The LFSR and config registers are don't-care.

Run sequence, counting edge 1 as the first edge that samples `init` low:
- Edge 1: IDLE → RD_PRE.
- Edges 2–4: capture P, taps, seed → RUN.
- Edges 5..68: commit bytes k = 0..63.
- After edge 68: state DONE, `done` = 1.
- Total: 68 cycles from start to `done`.

Boundary conditions:
- `init` high mid-run: on that edge, return to IDLE. No further writes; bytes already written remain. `done` = 0.
- `init` falling again after DONE starts a fresh run.
- P = 24: the message occupies addresses 0..39. Reads never exceed address 63−P.
- Write-data path: one XOR level plus parity. No pipeline latency beyond the registered k and LFSR.

## Structure

Package `enc_pkg` holds:
- the tap table (8×8 constant);
- address constants: PRE_ADDR 61, TAP_ADDR 62, SEED_ADDR 63, CT_BASE 64;
- the state enum.

Sub-module `lfsr8`:
- 8-bit register with `load` (seed) and `adv`;
- taps as an input;
- output is the current state.

The top level holds the FSM, the k counter, the P clamp and the parity/XOR datapath.

## Test plan

- **Basic keystream.** Seed 01, tap 0 (E1), P = 9, message "A" at address 0.
  - mem[64..66] = A1, A3, A7.
  - mem[73] = 41 XOR s9.
  - `done` rises on edge 68.
- **Seed zero.** Seed 00, otherwise as the basic test. Ciphertext is identical to the seed-01 run.
- **Clamping.**
  - P = 3: mem[64..72] are encrypted spaces; mem[73] encrypts mem[0].
  - P = 200: the first message byte lands at address 88.
- **Parity.** Character 43 ('C', three ones) encodes as C3 before the XOR. Bit 7 set in the stored character is ignored.
- **Abort and restart.** Raise `init` at RUN k = 20.
  - No writes to address 85 or above.
  - `done` stays 0.
  - A restart completes normally.
- **Round trip.** Run all 8 tap indices with random seed and P, then feed memory to the downstream decoder.
  - Decoded mem[0..63−P] equals the plaintext.
  - The recovered tap index matches.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and types for the LFSR message encoder: tap table,
// data-memory address map and controller states.
package enc_pkg;

  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] TAP_ADDR  = 8'd62;
  localparam logic [7:0] SEED_ADDR = 8'd63;
  localparam logic [7:0] CT_BASE   = 8'd64;

  // Packed so that TAP_TABLE[i] is entry i; the concatenation lists index 7 first.
  localparam logic [7:0][7:0] TAP_TABLE = {
    8'hF3, 8'hFA, 8'hB2, 8'hB4, 8'hB8, 8'hC6, 8'hD4, 8'hE1
  };

  typedef enum logic [2:0] {
    IDLE,
    RD_PRE,
    RD_TAP,
    RD_SEED,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR: shifts left, feedback is the XOR of the tapped bits.
module lfsr8 (
  input  logic       clk,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       adv,
  input  logic [7:0] taps,
  output logic [7:0] state
);

  // NOTE: the keystream register has no reset; it is always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (adv) begin
      state <= {state[6:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encoder.sv
// Reads preamble length, tap select and seed from data memory, then writes
// MSG_LEN parity-tagged, LFSR-whitened bytes (space preamble, then message).
module lfsr_encoder
  import enc_pkg::*;
#(
  parameter int MSG_LEN = 64,
  parameter int PRE_MIN = 9,
  parameter int PRE_MAX = 24
) (
  input  logic       clk,
  input  logic       init,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       done
);

  state_t     state, state_nxt;
  logic [7:0] k;
  logic [7:0] pre_len;
  logic [7:0] taps;
  logic [7:0] lfsr_q;
  logic [7:0] seed_fix;
  logic       lfsr_load;
  logic       run_wr;
  logic       in_msg;
  logic [6:0] chr;

  assign in_msg   = (k >= pre_len);
  assign seed_fix = (rd_data == 8'h00) ? 8'h01 : rd_data;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (init) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= (state == RUN) ? k + 8'd1 : '0;
    end
  end

  // Configuration is only meaningful once captured, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == RD_PRE) begin
      if (rd_data < 8'(PRE_MIN))      pre_len <= 8'(PRE_MIN);
      else if (rd_data > 8'(PRE_MAX)) pre_len <= 8'(PRE_MAX);
      else                            pre_len <= rd_data;
    end
    if (state == RD_TAP) begin
      taps <= TAP_TABLE[rd_data[2:0]];
    end
  end

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_nxt = state;
    rd_addr   = '0;
    run_wr    = 1'b0;
    lfsr_load = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:    state_nxt = RD_PRE;
      RD_PRE: begin
        rd_addr   = PRE_ADDR;
        state_nxt = RD_TAP;
      end
      RD_TAP: begin
        rd_addr   = TAP_ADDR;
        state_nxt = RD_SEED;
      end
      RD_SEED: begin
        rd_addr   = SEED_ADDR;
        lfsr_load = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        rd_addr = in_msg ? (k - pre_len) : '0;
        run_wr  = 1'b1;
        if (k == 8'(MSG_LEN - 1)) state_nxt = DONE;
      end
      DONE:    done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // An abort edge must not commit the byte that happens to be on the bus.
  assign wr_en   = run_wr & ~init;
  assign chr     = in_msg ? rd_data[6:0] : 7'h20;
  assign wr_addr = CT_BASE + k;
  assign wr_data = {^chr, chr} ^ lfsr_q;

  lfsr8 u_lfsr (
    .clk   (clk),
    .load  (lfsr_load),
    .seed  (seed_fix),
    .adv   (wr_en),
    .taps  (taps),
    .state (lfsr_q)
  );

endmodule

// File: tb/tb_lfsr_encoder.sv
// Self-checking bench for lfsr_encoder: behavioural data memory, per-byte
// scoreboard, vector table, abort/restart and a tap-recovering decoder.
module tb_lfsr_encoder;

  localparam int MSG_LEN = 64;
  localparam int PRE_MIN = 9;
  localparam int PRE_MAX = 24;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
  logic       wr_en, done;
  logic [7:0] mem [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] p_raw;
    logic [7:0] tap_byte;
    logic [7:0] seed;
    logic [7:0] c0;
    logic [7:0] exp_b0;
    logic [7:0] exp_msg_addr;
    logic [7:0] exp_msg_ct;
    bit         chk_ct;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];

  lfsr_encoder #(.MSG_LEN(MSG_LEN), .PRE_MIN(PRE_MIN), .PRE_MAX(PRE_MAX)) dut (
    .clk     (clk),
    .init    (init),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .done    (done)
  );

  always #5 clk = ~clk;
  assign rd_data = mem[rd_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tap_of(input int i);
    case (i)
      0: return 8'hE1;
      1: return 8'hD4;
      2: return 8'hC6;
      3: return 8'hB8;
      4: return 8'hB4;
      5: return 8'hB2;
      6: return 8'hFA;
      default: return 8'hF3;
    endcase
  endfunction

  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
    logic fb = 1'b0;
    for (int b = 0; b < 8; b++) fb = fb ^ (s[b] & t[b]);
    return {s[6:0], fb};
  endfunction

  function automatic int clamp_p(input logic [7:0] p);
    if (int'(p) < PRE_MIN) return PRE_MIN;
    if (int'(p) > PRE_MAX) return PRE_MAX;
    return int'(p);
  endfunction

  // Reference keystream model: expected {addr,data} for every byte of a run.
  task automatic build_expect();
    int         p = clamp_p(mem[61]);
    logic [7:0] s = (mem[63] == 8'h00) ? 8'h01 : mem[63];
    logic [7:0] t = tap_of(int'(mem[62][2:0]));
    logic [6:0] c;
    logic       par;
    wr_t        w;
    exp_q.delete();
    for (int k = 0; k < MSG_LEN; k++) begin
      c   = (k < p) ? 7'h20 : mem[k - p][6:0];
      par = 1'b0;
      for (int b = 0; b < 7; b++) par = par ^ c[b];
      w.addr = 8'(64 + k);
      w.data = {par, c} ^ s;
      exp_q.push_back(w);
      s = step(s, t);
    end
  endtask

  task automatic fill_mem(input logic [7:0] p, input logic [7:0] tb, input logic [7:0] sd);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[61] = p;
    mem[62] = tb;
    mem[63] = sd;
  endtask

  // One encoder run; abort_k >= 0 raises init while byte abort_k is on the bus.
  task automatic run_enc(input int abort_k, output int done_cyc, output logic [7:0] max_rd);
    wr_t w;
    int  nwr;
    init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_wr_en", wr_en, 0);
    check("idle_rd_addr", rd_addr, 0);
    build_expect();
    done_cyc = -1;
    max_rd   = 8'h00;
    init     = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("rd_pre_addr", rd_addr, 61);
      if (cyc == 2) check("rd_tap_addr", rd_addr, 62);
      if (cyc == 3) check("rd_seed_addr", rd_addr, 63);
      if (wr_en) begin
        if (abort_k >= 0 && wr_addr == 8'(64 + abort_k)) begin
          init = 1'b1;
          #1;
          check("abort_gates_wr_en", wr_en, 0);
          break;
        end
        if (rd_addr > max_rd) max_rd = rd_addr;
        if (exp_q.size() == 0) begin
          check("unexpected_write", wr_addr, 8'hFF);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", wr_addr, w.addr);
          check("wr_data", wr_data, w.data);
        end
        mem[wr_addr] = wr_data;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (abort_k >= 0) begin
      nwr = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (wr_en) nwr++;
        if (done) nwr++;
      end
      check("abort_no_writes_or_done", nwr, 0);
      check("abort_idle_rd_addr", rd_addr, 0);
      exp_q.delete();
    end else begin
      check("done_cycle", done_cyc, 68);
      check("all_bytes_written", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      check("done_held", {done, wr_en}, 2'b10);
    end
  endtask

  initial begin
    vec_t       vt[7];
    int         dc, rec, errs, p, sel;
    logic [7:0] mx, s, s0, pt;
    bit         ok;

    vt[0] = '{8'd9,   8'h00, 8'h01, 8'h41, 8'hA1, 8'd73, 8'hB3, 1'b1};
    vt[1] = '{8'd9,   8'h00, 8'h00, 8'h41, 8'hA1, 8'd73, 8'hB3, 1'b1};
    vt[2] = '{8'd3,   8'hF9, 8'h5A, 8'h41, 8'hFA, 8'd73, 8'h00, 1'b0};
    vt[3] = '{8'd200, 8'h02, 8'hFF, 8'h55, 8'h5F, 8'd88, 8'h00, 1'b0};
    vt[4] = '{8'd24,  8'h03, 8'h80, 8'h7E, 8'h20, 8'd88, 8'h00, 1'b0};
    vt[5] = '{8'd16,  8'h07, 8'h33, 8'hC3, 8'h93, 8'd80, 8'h00, 1'b0};
    vt[6] = '{8'd9,   8'h00, 8'h01, 8'hC3, 8'hA1, 8'd73, 8'h31, 1'b1};

    for (int i = 0; i < 7; i++) begin
      fill_mem(vt[i].p_raw, vt[i].tap_byte, vt[i].seed);
      mem[0] = vt[i].c0;
      run_enc(-1, dc, mx);
      check($sformatf("v%0d_byte0", i), mem[64], vt[i].exp_b0);
      check($sformatf("v%0d_max_rd", i), mx, 8'(63) - vt[i].exp_msg_addr + 8'd64);
      if (vt[i].chk_ct) check($sformatf("v%0d_msg_ct", i), mem[vt[i].exp_msg_addr], vt[i].exp_msg_ct);
      if (i == 0) begin
        check("basic_byte1", mem[65], 8'hA3);
        check("basic_byte2", mem[66], 8'hA7);
      end
    end

    // Abort at k = 20, then a clean restart from the same configuration.
    fill_mem(8'd9, 8'h00, 8'h01);
    mem[0] = 8'h41;
    run_enc(20, dc, mx);
    run_enc(-1, dc, mx);
    check("restart_msg_ct", mem[73], 8'hB3);

    // Round trip: blind decoder recovers taps from the space preamble.
    for (int t = 0; t < 8; t++) begin
      fill_mem(8'($urandom_range(0, 255)), {5'($urandom_range(0, 31)), 3'(t)},
               8'($urandom_range(0, 255)));
      run_enc(-1, dc, mx);
      p   = clamp_p(mem[61]);
      s0  = mem[64] ^ 8'hA0;
      rec = -1;
      for (int c = 0; c < 8; c++) begin
        s  = s0;
        ok = 1'b1;
        for (int k = 0; k < PRE_MIN; k++) begin
          if ((mem[64 + k] ^ s) != 8'hA0) ok = 1'b0;
          s = step(s, tap_of(c));
        end
        if (ok && rec < 0) rec = c;
      end
      sel = t;
      check($sformatf("rt%0d_tap", t), rec, sel);
      errs = 0;
      s    = s0;
      for (int k = 0; k < MSG_LEN; k++) begin
        pt = mem[64 + k] ^ s;
        if (k >= p && (pt[6:0] != mem[k - p][6:0] || pt[7] != ^pt[6:0])) errs++;
        s = step(s, tap_of(sel));
      end
      check($sformatf("rt%0d_plain", t), errs, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
